// File: rtl/sprite_line_scheduler_if.sv
// Bus bundle between the sprite line scheduler and the sprite controller / ROM / line buffer.
// master = scheduler side (owns ROM address and line-buffer write port), slave = controller side.
interface sprite_line_scheduler_if;
  logic        tbl_we;
  logic [4:0]  tbl_addr;
  logic [31:0] tbl_data;
  logic        line_start;
  logic [9:0]  line_num;
  logic [14:0] rom_addr;
  logic [11:0] rom_data;
  logic        lb_we;
  logic [9:0]  lb_addr;
  logic [11:0] lb_data;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        late;

  modport master (
    input  tbl_we, tbl_addr, tbl_data, line_start, line_num, rom_data,
    output rom_addr, lb_we, lb_addr, lb_data, busy, done, ovf, late
  );

  modport slave (
    output tbl_we, tbl_addr, tbl_data, line_start, line_num, rom_data,
    input  rom_addr, lb_we, lb_addr, lb_data, busy, done, ovf, late
  );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-line sprite fill: scans the attribute table on line_start, fetches each covering sprite's row
// from the ROM and writes its opaque pixels to the line buffer; no backpressure, SPR_W+1 cycles/sprite.
module sprite_line_scheduler #(
  parameter int NSPR         = 20,
  parameter int SPR_W        = 32,
  parameter int SPR_H        = 32,
  parameter int MAX_PER_LINE = 8,
  parameter int H_ACTIVE     = 640
) (
  input logic                     clk,
  input logic                     reset,
  sprite_line_scheduler_if.master bus
);
  localparam int IDX_W = $clog2(NSPR);
  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = $clog2(SPR_H);
  localparam int CNT_W = $clog2(MAX_PER_LINE + 1);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FETCH, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic             tbl_en [NSPR];
  logic [4:0]       tbl_id [NSPR];
  logic [9:0]       tbl_x  [NSPR];
  logic [9:0]       tbl_y  [NSPR];

  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] count;
  logic [9:0]       cur_line;
  logic [4:0]       lat_id;
  logic [9:0]       lat_x;
  logic [ROW_W-1:0] lat_row;
  logic [COL_W-1:0] col;
  logic             wr_pend;
  logic [10:0]      wr_addr;
  logic             late_q;
  logic             busy_w;
  logic             hit, can_fetch, last_idx;
  logic [9:0]       sc_y;
  logic             unused_rsvd;

  assign unused_rsvd = ^bus.tbl_data[5:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSPR; i++) begin
        tbl_en[i] <= 1'b0;
        tbl_id[i] <= '0;
        tbl_x[i]  <= '0;
        tbl_y[i]  <= '0;
      end
    end else if (bus.tbl_we && (int'(bus.tbl_addr) < NSPR)) begin
      tbl_en[bus.tbl_addr] <= bus.tbl_data[31];
      tbl_id[bus.tbl_addr] <= bus.tbl_data[30:26];
      tbl_x[bus.tbl_addr]  <= bus.tbl_data[25:16];
      tbl_y[bus.tbl_addr]  <= bus.tbl_data[15:6];
    end
  end

  // Range test done in 11 bits so y near the top of the 10-bit range cannot wrap.
  assign sc_y      = tbl_y[idx];
  assign hit       = (state == S_SCAN) && tbl_en[idx] &&
                     ({1'b0, cur_line} >= {1'b0, sc_y}) &&
                     ({1'b0, cur_line} < ({1'b0, sc_y} + 11'(SPR_H)));
  assign can_fetch = hit && (count != CNT_W'(MAX_PER_LINE));
  assign last_idx  = (idx == IDX_W'(NSPR - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_IDLE;
      S_SCAN:  if (can_fetch) state_nxt = S_FETCH;
               else if (last_idx) state_nxt = S_DONE;
      S_FETCH: if (col == '1) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = last_idx ? S_DONE : S_SCAN;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.line_start) state_nxt = S_SCAN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      count    <= '0;
      cur_line <= '0;
      lat_id   <= '0;
      lat_x    <= '0;
      lat_row  <= '0;
      col      <= '0;
      wr_pend  <= 1'b0;
      wr_addr  <= '0;
      late_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_pend <= 1'b0;
      if (bus.line_start) begin
        // A new line always restarts from entry 0; any pending pixel of the old line is dropped.
        idx      <= '0;
        count    <= '0;
        cur_line <= bus.line_num;
        if (busy_w) late_q <= 1'b1;
      end else begin
        case (state)
          S_SCAN: begin
            if (can_fetch) begin
              lat_id  <= tbl_id[idx];
              lat_x   <= tbl_x[idx];
              lat_row <= ROW_W'(cur_line - sc_y);
              count   <= count + 1'b1;
              col     <= '0;
            end else if (!last_idx) begin
              idx <= idx + 1'b1;
            end
          end
          S_FETCH: begin
            wr_pend <= 1'b1;
            wr_addr <= {1'b0, lat_x} + 11'(col);
            col     <= col + 1'b1;
          end
          S_DRAIN: idx <= idx + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign busy_w       = (state == S_SCAN) || (state == S_FETCH) || (state == S_DRAIN);
  assign bus.busy     = busy_w;
  assign bus.done     = (state == S_DONE);
  assign bus.ovf      = hit && !can_fetch;
  assign bus.late     = late_q;
  assign bus.rom_addr = (state == S_FETCH) ? {lat_id, lat_row, col} : '0;
  assign bus.lb_we    = wr_pend && (bus.rom_data != '0) && (wr_addr < 11'(H_ACTIVE));
  assign bus.lb_addr  = wr_addr[9:0];
  assign bus.lb_data  = bus.lb_we ? bus.rom_data : '0;
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler: synchronous ROM model, line-buffer monitor, hand-computed expectations.
module tb_sprite_line_scheduler;
  logic clk;
  logic reset;
  sprite_line_scheduler_if bus();

  sprite_line_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int rom_mode = 0;

  function automatic logic [11:0] rom_fn(input logic [14:0] a, input int mode);
    case (mode)
      1:       rom_fn = a[0] ? 12'h0F0 : 12'h000;
      2:       rom_fn = 12'h800 + {7'd0, a[14:10]};
      default: rom_fn = 12'hF00;
    endcase
  endfunction

  always_ff @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr, rom_mode);

  // Monitor state
  logic [11:0] lb_mem [1024];
  int wr_cnt, wa_min, wa_max, even_wr, rom_cnt, rom_first, rom_last, ovf_cnt, done_cnt;

  always @(negedge clk) begin
    if (bus.lb_we) begin
      wr_cnt++;
      lb_mem[bus.lb_addr] = bus.lb_data;
      if (int'(bus.lb_addr) < wa_min) wa_min = int'(bus.lb_addr);
      if (int'(bus.lb_addr) > wa_max) wa_max = int'(bus.lb_addr);
      if (bus.lb_addr[0] == 1'b0) even_wr++;
    end
    if (bus.rom_addr != '0) begin
      if (rom_cnt == 0) rom_first = int'(bus.rom_addr);
      rom_last = int'(bus.rom_addr);
      rom_cnt++;
    end
    if (bus.ovf)  ovf_cnt++;
    if (bus.done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 1024; i++) lb_mem[i] = 12'h000;
    wr_cnt = 0; wa_min = 2047; wa_max = -1; even_wr = 0;
    rom_cnt = 0; rom_first = -1; rom_last = -1; ovf_cnt = 0; done_cnt = 0;
  endtask

  task automatic tbl_write(input int addr, input bit en, input int id, input int x, input int y);
    @(negedge clk);
    bus.tbl_we   = 1'b1;
    bus.tbl_addr = 5'(addr);
    bus.tbl_data = {en, 5'(id), 10'(x), 10'(y), 6'd0};
    @(negedge clk);
    bus.tbl_we   = 1'b0;
  endtask

  task automatic start_line(input int n);
    @(negedge clk);
    bus.line_start = 1'b1;
    bus.line_num   = 10'(n);
    @(negedge clk);
    bus.line_start = 1'b0;
  endtask

  // Counts rising edges after the one that sampled line_start until done is seen; -1 on timeout.
  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        cyc = i;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  int lat;

  initial begin
    reset = 1'b0;
    bus.tbl_we = 1'b0; bus.tbl_addr = '0; bus.tbl_data = '0;
    bus.line_start = 1'b0; bus.line_num = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_ovf", 32'(bus.ovf), 0);
    check("rst_late", 32'(bus.late), 0);
    check("rst_lb_we", 32'(bus.lb_we), 0);
    check("rst_rom_addr", 32'(bus.rom_addr), 0);
    reset = 1'b1;

    // 1: single sprite, id 1, line 5 -> rows 1024+160..1024+191
    rom_mode = 0;
    tbl_write(0, 1'b1, 1, 0, 0);
    clear_mon();
    start_line(5);
    wait_done(200, lat);
    check("t1_latency", 32'(lat), 53);
    check("t1_rom_first", 32'(rom_first), 1184);
    check("t1_rom_last", 32'(rom_last), 1215);
    check("t1_rom_cnt", 32'(rom_cnt), 32);
    check("t1_wr_cnt", 32'(wr_cnt), 32);
    check("t1_wa_min", 32'(wa_min), 0);
    check("t1_wa_max", 32'(wa_max), 31);
    check("t1_pix0", 32'(lb_mem[0]), 32'h F00);
    check("t1_pix31", 32'(lb_mem[31]), 32'hF00);
    check("t1_done_cnt", 32'(done_cnt), 1);
    check("t1_busy_after", 32'(bus.busy), 0);

    // 2: right-edge clipping at H_ACTIVE
    tbl_write(0, 1'b0, 1, 0, 0);
    tbl_write(3, 1'b1, 2, 620, 0);
    clear_mon();
    start_line(5);
    wait_done(200, lat);
    check("t2_latency", 32'(lat), 53);
    check("t2_wr_cnt", 32'(wr_cnt), 20);
    check("t2_wa_min", 32'(wa_min), 620);
    check("t2_wa_max", 32'(wa_max), 639);
    check("t2_pix639", 32'(lb_mem[639]), 32'hF00);

    // 3: overlapping sprites, higher index drawn last
    tbl_write(3, 1'b0, 2, 620, 0);
    tbl_write(2, 1'b1, 2, 100, 50);
    tbl_write(7, 1'b1, 7, 100, 45);
    rom_mode = 2;
    clear_mon();
    start_line(60);
    wait_done(300, lat);
    check("t3_latency", 32'(lat), 86);
    check("t3_wr_cnt", 32'(wr_cnt), 64);
    check("t3_rom_first", 32'(rom_first), 2368);
    check("t3_rom_last", 32'(rom_last), 7679);
    check("t3_pix100", 32'(lb_mem[100]), 32'h807);
    check("t3_pix131", 32'(lb_mem[131]), 32'h807);

    // 4: ten hits on line 0, only eight fetched
    for (int i = 0; i < 10; i++) tbl_write(i, 1'b1, i, i * 40, 0);
    rom_mode = 0;
    clear_mon();
    start_line(0);
    wait_done(1000, lat);
    check("t4_latency", 32'(lat), 284);
    check("t4_wr_cnt", 32'(wr_cnt), 256);
    check("t4_ovf_cnt", 32'(ovf_cnt), 2);
    check("t4_done_cnt", 32'(done_cnt), 1);

    // 5: transparent even columns; last row covered, then first row past the sprite
    for (int i = 0; i < 10; i++) tbl_write(i, 1'b0, 0, 0, 0);
    tbl_write(5, 1'b1, 3, 200, 8);
    rom_mode = 1;
    clear_mon();
    start_line(39);
    wait_done(200, lat);
    check("t5_latency", 32'(lat), 53);
    check("t5_wr_cnt", 32'(wr_cnt), 16);
    check("t5_even_wr", 32'(even_wr), 0);
    check("t5_wa_min", 32'(wa_min), 201);
    check("t5_wa_max", 32'(wa_max), 231);
    clear_mon();
    start_line(40);
    wait_done(200, lat);
    check("t5_nohit_latency", 32'(lat), 20);
    check("t5_nohit_wr_cnt", 32'(wr_cnt), 0);
    check("t5_nohit_rom_cnt", 32'(rom_cnt), 0);
    check("t5_late_clear", 32'(bus.late), 0);

    // 6: second line_start mid-fetch aborts the line
    rom_mode = 0;
    clear_mon();
    start_line(20);
    repeat (9) @(negedge clk);
    start_line(500);
    wait_done(200, lat);
    check("t6_new_latency", 32'(lat), 20);
    check("t6_wr_cnt", 32'(wr_cnt), 4);
    check("t6_rom_cnt", 32'(rom_cnt), 5);
    check("t6_rom_first", 32'(rom_first), 3456);
    check("t6_pix203", 32'(lb_mem[203]), 32'hF00);
    check("t6_pix204", 32'(lb_mem[204]), 0);
    check("t6_late", 32'(bus.late), 1);
    check("t6_done_cnt", 32'(done_cnt), 1);

    // Reset in the middle of a fetch
    start_line(20);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mr_busy", 32'(bus.busy), 0);
    check("mr_late", 32'(bus.late), 0);
    check("mr_rom_addr", 32'(bus.rom_addr), 0);
    check("mr_lb_we", 32'(bus.lb_we), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_mon();
    start_line(20);
    wait_done(200, lat);
    check("mr_latency", 32'(lat), 20);
    check("mr_wr_cnt", 32'(wr_cnt), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
